// File: rtl/term_char_writer.sv
// term_char_writer: byte-stream command sequencer driving the VGA char terminal write port
module term_char_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int TABW = 8,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [7:0] data,
  output logic       dstrobe,
  output logic [1:0] dtype,
  output logic [4:0] cur_row,
  output logic [6:0] cur_col
);
  typedef enum logic [3:0] {
    INIT_ROW, INIT_COL, IDLE, PUT, WRAP_ROW, SET_COL, SET_ROW, BS_COL1,
    BS_CHAR, BS_COL2, TAB, CLR_ROW, CLR_COL, CLR_CHAR, CLR_HOME_ROW, CLR_HOME_COL
  } state_t;
  localparam logic [1:0] T_CHAR = 2'd0;
  localparam logic [1:0] T_COL = 2'd1;
  localparam logic [1:0] T_ROW = 2'd2;
  state_t state;
  logic [4:0] clr_row, nrow;
  logic [6:0] clr_col, ncol;
  logic last_col, printable;
  always_comb begin
    last_col = cur_col == 7'(COLS - 1);
    nrow = cur_row == 5'(ROWS - 1) ? 5'd0 : cur_row + 5'd1;
    ncol = last_col ? 7'd0 : cur_col + 7'd1;
    printable = in_data >= 8'h20 && in_data != 8'h7f;
  end
  assign in_ready = state == IDLE && !RST_I;
  task automatic emit(input logic [1:0] t, input logic [7:0] d);
    dstrobe <= 1'b1;
    dtype <= t;
    data <= d;
  endtask
  task automatic go(input state_t s);
    state <= s;
    busy <= s != IDLE;
  endtask
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= INIT_ROW;
      busy <= 1'b1;
      dstrobe <= 1'b0;
      dtype <= T_CHAR;
      data <= 8'h00;
      cur_row <= 5'd0;
      cur_col <= 7'd0;
      clr_row <= 5'd0;
      clr_col <= 7'd0;
    end else begin
      dstrobe <= 1'b0;
      case (state)
        INIT_ROW: begin emit(T_ROW, 8'h00); go(INIT_COL); end
        INIT_COL: begin emit(T_COL, 8'h00); go(IDLE); end
        IDLE: if (in_valid) begin
          if (printable) begin
            emit(T_CHAR, in_data); cur_col <= ncol; go(PUT);
          end else if (in_data == 8'h0d) begin
            emit(T_COL, 8'h00); cur_col <= 7'd0; go(SET_COL);
          end else if (in_data == 8'h0a) begin
            emit(T_ROW, {3'b0, nrow}); cur_row <= nrow; go(SET_ROW);
          end else if (in_data == 8'h08 && cur_col != 7'd0) begin
            emit(T_COL, {1'b0, cur_col - 7'd1}); cur_col <= cur_col - 7'd1; go(BS_COL1);
          end else if (in_data == 8'h09) begin
            emit(T_CHAR, FILL); cur_col <= ncol; go(TAB);
          end else if (in_data == 8'h0c) begin
            emit(T_ROW, 8'h00); cur_row <= 5'd0; clr_row <= 5'd0; go(CLR_ROW);
          end
        end
        PUT, TAB: begin
          if (cur_col == 7'd0) begin
            emit(T_ROW, {3'b0, nrow}); cur_row <= nrow; go(WRAP_ROW);
          end else if (state == PUT || (cur_col & 7'(TABW - 1)) == 7'd0) begin
            go(IDLE);
          end else begin
            emit(T_CHAR, FILL); cur_col <= ncol;
          end
        end
        BS_COL1: begin emit(T_CHAR, FILL); go(BS_CHAR); end
        BS_CHAR: begin emit(T_COL, {1'b0, cur_col}); go(BS_COL2); end
        CLR_ROW: begin emit(T_COL, 8'h00); cur_col <= 7'd0; go(CLR_COL); end
        CLR_COL: begin emit(T_CHAR, FILL); clr_col <= 7'd0; go(CLR_CHAR); end
        CLR_CHAR: begin
          if (clr_col != 7'(COLS - 1)) begin
            emit(T_CHAR, FILL); clr_col <= clr_col + 7'd1;
          end else if (clr_row == 5'(ROWS - 1)) begin
            emit(T_ROW, 8'h00); cur_row <= 5'd0; go(CLR_HOME_ROW);
          end else begin
            emit(T_ROW, {3'b0, clr_row + 5'd1}); cur_row <= clr_row + 5'd1;
            clr_row <= clr_row + 5'd1; go(CLR_ROW);
          end
        end
        CLR_HOME_ROW: begin emit(T_COL, 8'h00); cur_col <= 7'd0; go(CLR_HOME_COL); end
        default: go(IDLE);
      endcase
    end
  end
endmodule

// File: tb/tb_term_char_writer.sv
// tb_term_char_writer: directed + random byte stream against a strobe-list reference model
module tb_term_char_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int TABW = 8;
  localparam logic [7:0] FILL = 8'h20;
  logic clk = 1'b0;
  logic RST_I = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready, busy, dstrobe;
  logic [7:0] data;
  logic [1:0] dtype;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  int total = 0;
  int bad = 0;
  int mr = 0;
  int mc = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  term_char_writer #(.COLS(COLS), .ROWS(ROWS), .TABW(TABW), .FILL(FILL)) dut (
    .CLK_I(clk), .RST_I(RST_I), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .data(data), .dstrobe(dstrobe),
    .dtype(dtype), .cur_row(cur_row), .cur_col(cur_col)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask
  task automatic mput(input logic [7:0] ch);
    exp_q.push_back({2'd0, ch});
    mc++;
    if (mc == COLS) begin
      mc = 0;
      mr = (mr + 1) % ROWS;
      exp_q.push_back({2'd2, 8'(mr)});
    end
  endtask
  task automatic model(input logic [7:0] b);
    exp_q.delete();
    if (b == 8'h0d) begin
      mc = 0;
      exp_q.push_back({2'd1, 8'd0});
    end else if (b == 8'h0a) begin
      mr = (mr + 1) % ROWS;
      exp_q.push_back({2'd2, 8'(mr)});
    end else if (b == 8'h08) begin
      if (mc > 0) begin
        mc--;
        exp_q.push_back({2'd1, 8'(mc)});
        exp_q.push_back({2'd0, FILL});
        exp_q.push_back({2'd1, 8'(mc)});
      end
    end else if (b == 8'h09) begin
      do mput(FILL); while (mc % TABW != 0);
    end else if (b == 8'h0c) begin
      for (int r = 0; r < ROWS; r++) begin
        exp_q.push_back({2'd2, 8'(r)});
        exp_q.push_back({2'd1, 8'd0});
        for (int c = 0; c < COLS; c++) exp_q.push_back({2'd0, FILL});
      end
      exp_q.push_back({2'd2, 8'd0});
      exp_q.push_back({2'd1, 8'd0});
      mr = 0;
      mc = 0;
    end else if (b >= 8'h20 && b != 8'h7f) begin
      mput(b);
    end
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(in_ready), 1);
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    int gaps = 0;
    wait_ready();
    model(b);
    in_data = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 8'($urandom);
    @(negedge clk);
    chk($sformatf("first_%02h", b), 32'(dstrobe), 32'(exp_q.size() != 0));
    got_q.delete();
    while (1) begin
      if (dstrobe) got_q.push_back({dtype, data});
      else if (!in_ready) gaps++;
      if (in_ready || n >= 5000) break;
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_%02h", b), 32'(in_ready), 1);
    chk($sformatf("count_%02h", b), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("strobe_%02h_%0d", b, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk($sformatf("gaps_%02h", b), 32'(gaps), 0);
    chk($sformatf("busy_%02h", b), 32'(busy), 0);
    chk($sformatf("row_%02h", b), 32'(cur_row), 32'(mr));
    chk($sformatf("col_%02h", b), 32'(cur_col), 32'(mc));
  endtask
  task automatic do_reset();
    RST_I = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobe", 32'(dstrobe), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_cursor", {cur_row, cur_col}, 0);
    chk("rst_data", {dtype, data}, 0);
    RST_I = 1'b0;
    mr = 0;
    mc = 0;
    @(negedge clk);
    chk("init_row", {dstrobe, dtype, data}, {1'b1, 2'd2, 8'd0});
    chk("init_row_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("init_col", {dstrobe, dtype, data}, {1'b1, 2'd1, 8'd0});
    chk("init_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("init_idle_strobe", 32'(dstrobe), 0);
  endtask
  task automatic send_rand();
    int k = int'($urandom_range(0, 9));
    logic [7:0] junk[4] = '{8'h00, 8'h07, 8'h1b, 8'h7f};
    if (k < 5) send($urandom_range(0, 1) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(128, 255)));
    else if (k == 5) send(8'h0d);
    else if (k == 6) send(8'h0a);
    else if (k == 7) send(8'h08);
    else if (k == 8) send(8'h09);
    else send(junk[$urandom_range(0, 3)]);
  endtask
  initial begin
    do_reset();
    send(8'h41);
    chk("a_col", 32'(cur_col), 1);
    for (int i = 0; i < 60; i++) send_rand();
    while (mr != ROWS - 1) send(8'h0a);
    send(8'h0d);
    while (mc != COLS - 1) send(8'h78);
    send(8'h5a);
    chk("wrap_cursor", {cur_row, cur_col}, 0);
    send(8'h0d);
    send(8'h41);
    send(8'h42);
    send(8'h08);
    chk("bs_col", 32'(cur_col), 1);
    send(8'h0d);
    send(8'h08);
    chk("bs0_col", 32'(cur_col), 0);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(8'h09);
    chk("tab_col", 32'(cur_col), 8);
    send(8'h0d);
    while (mr != ROWS - 1) send(8'h0a);
    send(8'h0a);
    chk("lf_wrap_row", 32'(cur_row), 0);
    send(8'h0c);
    chk("ff_count", 32'(got_q.size()), 2462);
    wait_ready();
    in_data = 8'h0c;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (300) @(negedge clk);
    chk("midclr_strobe", 32'(dstrobe), 1);
    chk("midclr_busy", 32'(busy), 1);
    RST_I = 1'b1;
    @(negedge clk);
    chk("abort_strobe", 32'(dstrobe), 0);
    do_reset();
    send(8'h07);
    for (int i = 0; i < 60; i++) send_rand();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
